// File: rtl/waveform_sample_packer_pkg.sv
// Shared definitions for the waveform sample packer and its recorder-side consumers.
package waveform_sample_packer_pkg;

  localparam int unsigned DEF_SAMPLE_WIDTH    = 16;
  localparam int unsigned DEF_LANES           = 8;
  localparam int unsigned DEF_TRIGGER_WIDTH   = 8;
  localparam int unsigned DEF_TIMESTAMP_WIDTH = 64;

  // Packed output word width for the default configuration.
  localparam int unsigned DEF_WORD_WIDTH = DEF_SAMPLE_WIDTH * DEF_LANES;

  // Trigger vector as seen by the recorder.
  typedef logic [DEF_TRIGGER_WIDTH-1:0] trig_vec_t;

  // Width of a lane index; a single lane still needs one bit to be a legal vector.
  function automatic int unsigned lane_idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Width of one packed word.
  function automatic int unsigned word_width(input int unsigned sample_w,
                                             input int unsigned lanes);
    return sample_w * lanes;
  endfunction

endpackage

// File: rtl/waveform_sample_packer_if.sv
// Sample-in / packed-word-out bundle between the feeder and the packer.
interface waveform_sample_packer_if
  import waveform_sample_packer_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
  parameter int unsigned LANES           = DEF_LANES,
  parameter int unsigned TRIGGER_WIDTH   = DEF_TRIGGER_WIDTH,
  parameter int unsigned TIMESTAMP_WIDTH = DEF_TIMESTAMP_WIDTH
);

  localparam int unsigned WORD_W = word_width(SAMPLE_WIDTH, LANES);
  localparam int unsigned LANE_W = lane_idx_width(LANES);

  // Narrow sample side
  logic [SAMPLE_WIDTH-1:0]    in_data;
  logic                       in_valid;
  logic [TRIGGER_WIDTH-1:0]   in_triggers;
  logic [TIMESTAMP_WIDTH-1:0] in_timestamp;

  // Wide word side towards the recorder
  logic [WORD_W-1:0]          out_data;
  logic                       out_valid;
  logic [TRIGGER_WIDTH-1:0]   out_triggers;
  logic [LANE_W-1:0]          out_trig_lane;
  logic [TIMESTAMP_WIDTH-1:0] out_timestamp;

  // Feeder / testbench side
  modport master (
    output in_data, in_valid, in_triggers, in_timestamp,
    input  out_data, out_valid, out_triggers, out_trig_lane, out_timestamp
  );

  // Packer side
  modport slave (
    input  in_data, in_valid, in_triggers, in_timestamp,
    output out_data, out_valid, out_triggers, out_trig_lane, out_timestamp
  );

endinterface

// File: rtl/waveform_sample_packer.sv
// Packs sparse narrow samples into LANES-wide words for the waveform recorder, carrying the
// union of triggers seen during each word and the lane of the first one.
module waveform_sample_packer
  import waveform_sample_packer_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
  parameter int unsigned LANES           = DEF_LANES,
  parameter int unsigned TRIGGER_WIDTH   = DEF_TRIGGER_WIDTH,
  parameter int unsigned TIMESTAMP_WIDTH = DEF_TIMESTAMP_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic                    i_sync_clear,
  input logic                    i_test_mode,
  waveform_sample_packer_if.slave io_bus
);

  localparam int unsigned LANE_W = lane_idx_width(LANES);
  localparam int unsigned WORD_W = word_width(SAMPLE_WIDTH, LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  // Word assembly state
  logic [LANE_W-1:0]          r_cnt;
  logic [WORD_W-1:0]          r_word;
  logic [TIMESTAMP_WIDTH-1:0] r_ts_cap;
  logic [SAMPLE_WIDTH-1:0]    r_test_cnt;

  // Trigger accumulation state
  logic [TRIGGER_WIDTH-1:0]   r_acc;
  logic                       r_flag;
  logic [LANE_W-1:0]          r_trig_lane;

  // Registered outputs
  logic [WORD_W-1:0]          r_out_data;
  logic                       r_out_valid;
  logic [TRIGGER_WIDTH-1:0]   r_out_triggers;
  logic [LANE_W-1:0]          r_out_trig_lane;
  logic [TIMESTAMP_WIDTH-1:0] r_out_ts;

  logic [SAMPLE_WIDTH-1:0]    w_sample;
  logic                       w_accept;
  logic                       w_emit;
  logic                       w_trig_hit;
  logic [TRIGGER_WIDTH-1:0]   w_acc_all;
  logic [LANE_W-1:0]          w_first_lane;
  logic [WORD_W-1:0]          w_word_next;

  // sync_clear wins over in_valid, so a clearing cycle never accepts or emits.
  assign w_sample   = i_test_mode ? r_test_cnt : io_bus.in_data;
  assign w_accept   = io_bus.in_valid & ~i_sync_clear;
  assign w_emit     = w_accept & (r_cnt == LAST_LANE);
  assign w_trig_hit = |io_bus.in_triggers;
  assign w_acc_all  = r_acc | io_bus.in_triggers;

  // A trigger arriving on the completing cycle itself is the first one if none preceded it.
  assign w_first_lane = r_flag     ? r_trig_lane :
                        w_trig_hit ? r_cnt       : '0;

  // Current word with the incoming sample dropped into its lane.
  always_comb begin
    w_word_next = r_word;
    w_word_next[int'(r_cnt) * SAMPLE_WIDTH +: SAMPLE_WIDTH] = w_sample;
  end

  // Lane counter, word buffer, lane-0 timestamp and test pattern counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_word     <= '0;
      r_ts_cap   <= '0;
      r_test_cnt <= '0;
    end else if (i_sync_clear) begin
      r_cnt      <= '0;
      r_test_cnt <= '0;
    end else if (io_bus.in_valid) begin
      r_word <= w_word_next;
      if (r_cnt == '0) begin
        r_ts_cap <= io_bus.in_timestamp;
      end
      if (i_test_mode) begin
        r_test_cnt <= r_test_cnt + 1'b1;
      end
      r_cnt <= w_emit ? '0 : r_cnt + 1'b1;
    end
  end

  // Trigger accumulator and first-trigger lane capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_flag      <= 1'b0;
      r_trig_lane <= '0;
    end else if (i_sync_clear) begin
      // Triggers coinciding with the restart belong to the next word, at lane 0.
      r_acc       <= io_bus.in_triggers;
      r_flag      <= w_trig_hit;
      r_trig_lane <= '0;
    end else if (w_emit) begin
      r_acc       <= '0;
      r_flag      <= 1'b0;
      r_trig_lane <= '0;
    end else begin
      r_acc <= w_acc_all;
      if (w_trig_hit && !r_flag) begin
        r_flag      <= 1'b1;
        r_trig_lane <= r_cnt;
      end
    end
  end

  // Output word register; everything except the strobe holds between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_triggers  <= '0;
      r_out_trig_lane <= '0;
      r_out_ts        <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_data      <= w_word_next;
        r_out_triggers  <= w_acc_all;
        r_out_trig_lane <= w_first_lane;
        r_out_ts        <= r_ts_cap;
      end
    end
  end

  assign io_bus.out_data      = r_out_data;
  assign io_bus.out_valid     = r_out_valid;
  assign io_bus.out_triggers  = r_out_triggers;
  assign io_bus.out_trig_lane = r_out_trig_lane;
  assign io_bus.out_timestamp = r_out_ts;

endmodule

// File: tb/tb_waveform_sample_packer.sv
// Bench for waveform_sample_packer: directed tables, hand sequences and random traffic
// compared against a queue-based word model.
module tb_waveform_sample_packer;
  import waveform_sample_packer_pkg::*;

  localparam int unsigned SW  = 16;
  localparam int unsigned LN  = 8;
  localparam int unsigned TW  = 8;
  localparam int unsigned TSW = 64;
  localparam int unsigned WW  = SW * LN;
  localparam int unsigned LW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_clear = 1'b0;
  logic test_mode = 1'b0;
  logic [TSW-1:0] ts_ctr = 64'h0000_0007_0000_0100;

  waveform_sample_packer_if #(
    .SAMPLE_WIDTH(SW), .LANES(LN), .TRIGGER_WIDTH(TW), .TIMESTAMP_WIDTH(TSW)
  ) bus ();

  waveform_sample_packer #(
    .SAMPLE_WIDTH(SW), .LANES(LN), .TRIGGER_WIDTH(TW), .TIMESTAMP_WIDTH(TSW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sync_clear(sync_clear),
    .i_test_mode (test_mode),
    .io_bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts_ctr <= ts_ctr + 64'd1;
  assign bus.in_timestamp = ts_ctr;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [TSW-1:0] last_ts;

  // Reference model: the current word is just a queue of accepted samples.
  logic [SW-1:0]  m_lanes[$];
  logic [TSW-1:0] m_ts0;
  logic [TW-1:0]  m_acc;
  int             m_first;
  logic [SW-1:0]  m_tcnt;
  logic           m_valid;
  logic [WW-1:0]  m_data;
  logic [TW-1:0]  m_trig;
  logic [LW-1:0]  m_lane;
  logic [TSW-1:0] m_ts;

  task automatic model_reset();
    m_lanes.delete();
    m_ts0 = '0; m_acc = '0; m_first = -1; m_tcnt = '0;
    m_valid = 1'b0; m_data = '0; m_trig = '0; m_lane = '0; m_ts = '0;
  endtask

  task automatic model_step(input logic sc, input logic tm, input logic [SW-1:0] d,
                            input logic v, input logic [TW-1:0] tr, input logic [TSW-1:0] ts);
    logic [SW-1:0] s;
    m_valid = 1'b0;
    if (sc) begin
      m_lanes.delete();
      m_tcnt  = '0;
      m_acc   = tr;
      m_first = (tr != '0) ? 0 : -1;
    end else begin
      if (tr != '0 && m_first < 0) m_first = m_lanes.size();
      m_acc = m_acc | tr;
      if (v) begin
        s = tm ? m_tcnt : d;
        if (tm) m_tcnt = m_tcnt + 1'b1;
        if (m_lanes.size() == 0) m_ts0 = ts;
        m_lanes.push_back(s);
        if (m_lanes.size() == LN) begin
          m_valid = 1'b1;
          for (int i = 0; i < LN; i++) m_data[i*SW +: SW] = m_lanes[i];
          m_trig  = m_acc;
          m_lane  = (m_first < 0) ? '0 : LW'(m_first);
          m_ts    = m_ts0;
          m_lanes.delete();
          m_acc   = '0;
          m_first = -1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", WW'(bus.out_valid), WW'(m_valid));
    chk("out_data", bus.out_data, m_data);
    chk("out_triggers", WW'(bus.out_triggers), WW'(m_trig));
    chk("out_trig_lane", WW'(bus.out_trig_lane), WW'(m_lane));
    chk("out_timestamp", WW'(bus.out_timestamp), WW'(m_ts));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, WW'(bus.out_valid), '0);
    chk({tag, ".data"}, bus.out_data, '0);
    chk({tag, ".triggers"}, WW'(bus.out_triggers), '0);
    chk({tag, ".trig_lane"}, WW'(bus.out_trig_lane), '0);
    chk({tag, ".timestamp"}, WW'(bus.out_timestamp), '0);
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1ns later.
  task automatic cycle(input logic sc, input logic tm, input logic [SW-1:0] d,
                       input logic v, input logic [TW-1:0] tr);
    logic [TSW-1:0] ts;
    sync_clear = sc; test_mode = tm;
    bus.in_data = d; bus.in_valid = v; bus.in_triggers = tr;
    ts = ts_ctr;
    last_ts = ts;
    @(posedge clk);
    model_step(sc, tm, d, v, tr, ts);
    if (m_valid) strobes++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, test_mode, SW'($urandom), 1'b0, '0);
  endtask

  function automatic logic [WW-1:0] seq_word(input int base);
    logic [WW-1:0] w;
    for (int i = 0; i < LN; i++) w[i*SW +: SW] = SW'(base + i);
    return w;
  endfunction

  typedef struct {
    logic          v;
    logic [SW-1:0] d;
    logic [TW-1:0] tr;
    logic          ev;
    logic [TW-1:0] etr;
    logic [LW-1:0] elane;
    int            ebase;
  } vec_t;

  vec_t          tbl[$];
  trig_vec_t     rtr;
  logic [TSW-1:0] lane0_ts;
  int            s0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_triggers = '0;
    model_reset();
    #2;
    check_zero("reset");
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two words, one sample every 10th cycle, one trigger pulse between samples 2 and 3.
    for (int i = 0; i < 16; i++) begin
      if (i == 3) tbl.push_back('{1'b0, '0, 8'h01, 1'b0, '0, '0, 0});
      tbl.push_back('{1'b1, SW'(i), '0, (i % 8) == 7, (i == 7) ? 8'h01 : 8'h00,
                      (i == 7) ? 3'd3 : 3'd0, i - 7});
    end
    foreach (tbl[k]) begin
      cycle(1'b0, 1'b0, tbl[k].d, tbl[k].v, tbl[k].tr);
      if (tbl[k].v && tbl[k].d[2:0] == 3'd0) lane0_ts = last_ts;
      chk("tbl.valid", WW'(bus.out_valid), WW'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk("tbl.data", bus.out_data, seq_word(tbl[k].ebase));
        chk("tbl.triggers", WW'(bus.out_triggers), WW'(tbl[k].etr));
        chk("tbl.trig_lane", WW'(bus.out_trig_lane), WW'(tbl[k].elane));
        chk("tbl.timestamp", WW'(bus.out_timestamp), WW'(lane0_ts));
      end
      if (tbl[k].v) idle(9);
    end

    // Trigger union across a word, including one on the completing cycle.
    cycle(1'b0, 1'b0, 16'h0a00, 1'b1, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, 8'h01);
    for (int i = 1; i < 4; i++) cycle(1'b0, 1'b0, SW'(16'h0a00 + i), 1'b1, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, 8'h10);
    for (int i = 4; i < 7; i++) cycle(1'b0, 1'b0, SW'(16'h0a00 + i), 1'b1, '0);
    cycle(1'b0, 1'b0, 16'h0a07, 1'b1, 8'h04);
    chk("union.valid", WW'(bus.out_valid), 1);
    chk("union.triggers", WW'(bus.out_triggers), WW'(8'h15));
    chk("union.trig_lane", WW'(bus.out_trig_lane), 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, SW'(i), 1'b1, '0);
    chk("union.next_triggers", WW'(bus.out_triggers), 0);

    // sync_clear mid-word with a simultaneous sample and trigger.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, SW'(100 + i), 1'b1, '0);
    s0 = strobes;
    cycle(1'b1, 1'b0, 16'd999, 1'b1, 8'h02);
    chk("clear.no_strobe", WW'(bus.out_valid), 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, SW'(200 + i), 1'b1, '0);
    chk("clear.strobes", WW'(strobes - s0), 1);
    chk("clear.data", bus.out_data, seq_word(200));
    chk("clear.triggers", WW'(bus.out_triggers), WW'(8'h02));
    chk("clear.trig_lane", WW'(bus.out_trig_lane), 0);

    // Test pattern: three words of 0..23, then restart from 0 after sync_clear.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'hdead, 1'b1, '0);
      chk("test.word", bus.out_data, seq_word(w * 8));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'hdead, 1'b1, '0);
    cycle(1'b1, 1'b1, 16'hdead, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'hdead, 1'b1, '0);
    chk("test.restart", bus.out_data, seq_word(0));

    // Asynchronous reset in the middle of a word.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, SW'(50 + i), 1'b1, 8'h08);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    bus.in_valid = 1'b0; bus.in_triggers = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    s0 = strobes;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, SW'(300 + i), 1'b1, '0);
      if (i == 0) lane0_ts = last_ts;
    end
    chk("rst.strobes", WW'(strobes - s0), 1);
    chk("rst.data", bus.out_data, seq_word(300));
    chk("rst.triggers", WW'(bus.out_triggers), 0);
    chk("rst.timestamp", WW'(bus.out_timestamp), WW'(lane0_ts));

    // Random sparse traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rtr = ($urandom_range(0, 19) == 0) ? trig_vec_t'($urandom) : '0;
      if ($urandom_range(0, 299) == 0) test_mode = ~test_mode;
      cycle($urandom_range(0, 199) == 0, test_mode, SW'($urandom),
            $urandom_range(0, 4) == 0, rtr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
